// File: rtl/disp_pkg.sv
// Shared display definitions: blank pattern, active-low glyphs, scan phase type
// and the slot counter width helper.
package disp_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] GLYPH_E   = 8'b00110001;
   localparam logic [7:0] GLYPH_O   = 8'b00000011;

   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_DRIVE = 1'b1
   } phase_e;

   function automatic int slot_width(input int digit_cyc);
      return (digit_cyc > 2) ? $clog2(digit_cyc) : 1;
   endfunction

   function automatic logic [7:0] glyph_digit(input logic [3:0] d);
      logic [7:0] g;
      g = SEG_BLANK;
      case (d)
         4'd0: g = 8'b00000011;
         4'd1: g = 8'b10011111;
         4'd2: g = 8'b00100101;
         4'd3: g = 8'b00001101;
         4'd4: g = 8'b10011001;
         4'd5: g = 8'b01001001;
         4'd6: g = 8'b01000001;
         4'd7: g = 8'b00011111;
         4'd8: g = 8'b00000001;
         4'd9: g = 8'b00001001;
         default: g = SEG_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// Pattern input and pin-level outputs of the display scanner; the scanner
// takes the slave side, the pattern producer the master side.
interface seg_display_scanner_if #(
   parameter int N_LED    = 8,
   parameter int N_LED_AN = 4
);
   logic [N_LED*N_LED_AN-1:0] seg_data_i;
   logic                      load_i;
   logic [N_LED-1:0]          led_o;
   logic [N_LED_AN-1:0]       led_an_o;
   logic                      frame_o;

   modport master (output seg_data_i, load_i, input led_o, led_an_o, frame_o);
   modport slave  (input seg_data_i, load_i, output led_o, led_an_o, frame_o);
endinterface

// File: rtl/seg_display_scanner_refresh_counter.sv
// Slot counter and digit index for the scan; strobes the last cycle of a frame.
// Free-running, no stall input; strobes are combinational from registered state.
module refresh_counter
   import disp_pkg::*;
#(
   parameter int DIGIT_CYC = 100000,
   parameter int N_LED_AN  = 4,
   localparam int CW = slot_width(DIGIT_CYC),
   localparam int IW = (N_LED_AN > 1) ? $clog2(N_LED_AN) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic [CW-1:0] o_cnt,
   output logic [IW-1:0] o_idx,
   output logic          o_frame_end
);

   localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYC - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_LED_AN - 1);

   logic [CW-1:0] r_cnt;
   logic [IW-1:0] r_idx;
   logic          w_slot_end;

   assign w_slot_end  = (r_cnt == CNT_LAST);
   assign o_frame_end = w_slot_end && (r_idx == IDX_LAST);
   assign o_cnt       = r_cnt;
   assign o_idx       = r_idx;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_slot_end) begin
         r_cnt <= '0;
         r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed common-anode 7-segment driver with frame-aligned double buffering.
// Outputs registered one cycle behind the scan counter; load_i is always accepted.
module seg_display_scanner
   import disp_pkg::*;
#(
   parameter int N_LED     = 8,
   parameter int N_LED_AN  = 4,
   parameter int DIGIT_CYC = 100000,
   parameter int BLANK_CYC = 1000
) (
   input logic                   clk_i,
   input logic                   rst_i,
   seg_display_scanner_if.slave  bus
);

   localparam int CW = slot_width(DIGIT_CYC);
   localparam int IW = (N_LED_AN > 1) ? $clog2(N_LED_AN) : 1;
   localparam int DW = N_LED * N_LED_AN;

   if (DIGIT_CYC < 2) begin : g_bad_digit_cyc
      $error("seg_display_scanner: DIGIT_CYC must be at least 2");
   end
   if (BLANK_CYC < 1 || BLANK_CYC >= DIGIT_CYC) begin : g_bad_blank_cyc
      $error("seg_display_scanner: BLANK_CYC must satisfy 1 <= BLANK_CYC < DIGIT_CYC");
   end
   if (N_LED < 1 || N_LED_AN < 1) begin : g_bad_width
      $error("seg_display_scanner: N_LED and N_LED_AN must be positive");
   end

   logic [CW-1:0]       w_cnt;
   logic [IW-1:0]       w_idx;
   logic                w_frame_end;
   phase_e              w_phase;
   logic [N_LED-1:0]    w_led;
   logic [N_LED_AN-1:0] w_an;

   logic [DW-1:0]       r_staged;
   logic [DW-1:0]       r_shadow;
   logic                r_pending;
   logic [N_LED-1:0]    r_led;
   logic [N_LED_AN-1:0] r_an;
   logic                r_frame;

   refresh_counter #(
      .DIGIT_CYC (DIGIT_CYC),
      .N_LED_AN  (N_LED_AN)
   ) u_refresh_counter (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .o_cnt       (w_cnt),
      .o_idx       (w_idx),
      .o_frame_end (w_frame_end)
   );

   // A load on the frame-end cycle goes straight to the shadow so it is not lost a frame.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_staged  <= '1;
         r_shadow  <= '1;
         r_pending <= 1'b0;
      end else begin
         if (bus.load_i) begin
            r_staged <= bus.seg_data_i;
         end
         if (w_frame_end) begin
            if (bus.load_i) begin
               r_shadow <= bus.seg_data_i;
            end else if (r_pending) begin
               r_shadow <= r_staged;
            end
            r_pending <= 1'b0;
         end else if (bus.load_i) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign w_phase = (w_cnt < CW'(BLANK_CYC)) ? PH_BLANK : PH_DRIVE;

   always_comb begin
      w_led = '1;
      w_an  = '1;
      if (w_phase == PH_DRIVE) begin
         w_led = r_shadow[w_idx*N_LED +: N_LED];
         w_an  = ~(N_LED_AN'(1) << w_idx);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_led   <= '1;
         r_an    <= '1;
         r_frame <= 1'b0;
      end else begin
         r_led   <= w_led;
         r_an    <= w_an;
         r_frame <= w_frame_end;
      end
   end

   assign bus.led_o    = r_led;
   assign bus.led_an_o = r_an;
   assign bus.frame_o  = r_frame;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: a frame-level model predicts pins per cycle,
// and a background monitor watches anode exclusivity and blanking gaps.
module tb_seg_display_scanner;
   import disp_pkg::*;

   localparam int NL    = 8;
   localparam int NA    = 4;
   localparam int DC    = 8;
   localparam int BC    = 2;
   localparam int FRAME = NA * DC;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int vectors     = 0;
   int miscompares = 0;

   // Frame-level model: what is on the glass now, and what the next frame will show.
   int          t;
   logic [31:0] m_cur;
   logic [31:0] m_next;
   bit          m_has_next;
   logic [7:0]  exp_led;
   logic [3:0]  exp_an;
   logic        exp_frame;

   int last_an = -1;
   int off_cnt = 0;
   int inv_cur;

   seg_display_scanner_if #(.N_LED(NL), .N_LED_AN(NA)) bus();

   seg_display_scanner #(
      .N_LED     (NL),
      .N_LED_AN  (NA),
      .DIGIT_CYC (DC),
      .BLANK_CYC (BC)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      vectors++;
      if ($countones(~bus.led_an_o) > 1) begin
         miscompares++;
         $display("FAIL anode_exclusive: led_an_o=%b, required at most one low bit", bus.led_an_o);
      end
      if (bus.led_an_o == 4'hF) begin
         off_cnt++;
      end else begin
         inv_cur = 0;
         for (int i = 0; i < NA; i++) if (!bus.led_an_o[i]) inv_cur = i;
         if (last_an >= 0 && inv_cur != last_an) begin
            vectors++;
            if (off_cnt < BC) begin
               miscompares++;
               $display("FAIL blank_gap: %0d all-off cycles between anode %0d and %0d, required >= %0d",
                        off_cnt, last_an, inv_cur, BC);
            end
         end
         last_an = inv_cur;
         off_cnt = 0;
      end
   end

   task automatic model_reset();
      t          = 0;
      m_cur      = '1;
      m_next     = '1;
      m_has_next = 1'b0;
   endtask

   // Apply one cycle of input, predict the pins that cycle produces, advance the model.
   task automatic step(input bit ld, input logic [31:0] d);
      int p, dig, w;
      bus.load_i     = ld;
      bus.seg_data_i = d;
      p   = t % FRAME;
      dig = p / DC;
      w   = p % DC;
      if (w < BC) begin
         exp_led = 8'hFF;
         exp_an  = 4'hF;
      end else begin
         exp_led = m_cur[dig*NL +: NL];
         exp_an  = ~(4'b0001 << dig);
      end
      exp_frame = (p == FRAME - 1);
      if (ld) begin
         m_next     = d;
         m_has_next = 1'b1;
      end
      if (p == FRAME - 1) begin
         if (m_has_next) m_cur = m_next;
         m_has_next = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.load_i = 1'b0;
      t++;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus.load_i     = 1'b0;
      bus.seg_data_i = '0;
      repeat (3) begin
         @(posedge clk);
         #1;
         vectors++;
         if ({bus.led_o, bus.led_an_o, bus.frame_o} !== {8'hFF, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_hold: led=%h an=%h frame=%b, required led=ff an=f frame=0",
                     bus.led_o, bus.led_an_o, bus.frame_o);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < FRAME + DC; i++) begin
         step(1'b0, '0);
         vectors++;
         if ({bus.led_o, bus.led_an_o, bus.frame_o} !== {exp_led, exp_an, exp_frame}) begin
            miscompares++;
            $display("FAIL reset_scan t=%0d: led=%h an=%h frame=%b, required led=%h an=%h frame=%b",
                     t, bus.led_o, bus.led_an_o, bus.frame_o, exp_led, exp_an, exp_frame);
         end
      end
   endtask

   task automatic test_basic_load();
      logic [31:0] oeoe;
      oeoe = {GLYPH_O, GLYPH_E, GLYPH_O, GLYPH_E};
      for (int i = 0; i < 3 * FRAME; i++) begin
         step((t % FRAME) == 12 && i < FRAME, oeoe);
         vectors++;
         if ({bus.led_o, bus.led_an_o, bus.frame_o} !== {exp_led, exp_an, exp_frame}) begin
            miscompares++;
            $display("FAIL basic_load t=%0d: led=%h an=%h frame=%b, required led=%h an=%h frame=%b",
                     t, bus.led_o, bus.led_an_o, bus.frame_o, exp_led, exp_an, exp_frame);
         end
      end
   endtask

   task automatic test_coherence();
      logic [31:0] a, b;
      a = $urandom;
      b = ~a;
      for (int i = 0; i < 3 * FRAME; i++) begin
         if ((t % FRAME) == 10 && i < FRAME)      step(1'b1, a);
         else if ((t % FRAME) == 15 && i < FRAME) step(1'b1, b);
         else                                     step(1'b0, '0);
         vectors++;
         if ({bus.led_o, bus.led_an_o, bus.frame_o} !== {exp_led, exp_an, exp_frame}) begin
            miscompares++;
            $display("FAIL coherence t=%0d: led=%h an=%h frame=%b, required led=%h an=%h frame=%b",
                     t, bus.led_o, bus.led_an_o, bus.frame_o, exp_led, exp_an, exp_frame);
         end
      end
   endtask

   task automatic test_bypass();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         if ((t % FRAME) == FRAME - 1 && !done) begin
            step(1'b1, 32'h0000_0000);
            done = 1'b1;
         end else begin
            step(1'b0, '0);
         end
         vectors++;
         if ({bus.led_o, bus.led_an_o, bus.frame_o} !== {exp_led, exp_an, exp_frame}) begin
            miscompares++;
            $display("FAIL bypass t=%0d: led=%h an=%h frame=%b, required led=%h an=%h frame=%b",
                     t, bus.led_o, bus.led_an_o, bus.frame_o, exp_led, exp_an, exp_frame);
         end
      end
   endtask

   task automatic test_random_loads();
      for (int i = 0; i < 8 * FRAME; i++) begin
         step($urandom_range(0, 5) == 0, $urandom);
         vectors++;
         if ({bus.led_o, bus.led_an_o, bus.frame_o} !== {exp_led, exp_an, exp_frame}) begin
            miscompares++;
            $display("FAIL random_loads t=%0d: led=%h an=%h frame=%b, required led=%h an=%h frame=%b",
                     t, bus.led_o, bus.led_an_o, bus.frame_o, exp_led, exp_an, exp_frame);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] pat;
      while ((t % FRAME) != 2 * DC + 4) begin
         step(1'b0, '0);
         vectors++;
         if ({bus.led_o, bus.led_an_o, bus.frame_o} !== {exp_led, exp_an, exp_frame}) begin
            miscompares++;
            $display("FAIL reset_mid_pre t=%0d: led=%h an=%h frame=%b, required led=%h an=%h frame=%b",
                     t, bus.led_o, bus.led_an_o, bus.frame_o, exp_led, exp_an, exp_frame);
         end
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({bus.led_o, bus.led_an_o, bus.frame_o} !== {8'hFF, 4'hF, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_mid_async: led=%h an=%h frame=%b, required led=ff an=f frame=0 before any edge",
                  bus.led_o, bus.led_an_o, bus.frame_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      pat = $urandom;
      for (int i = 0; i < 4 * FRAME; i++) begin
         step(i == FRAME + 5, pat);
         vectors++;
         if ({bus.led_o, bus.led_an_o, bus.frame_o} !== {exp_led, exp_an, exp_frame}) begin
            miscompares++;
            $display("FAIL reset_mid_after t=%0d: led=%h an=%h frame=%b, required led=%h an=%h frame=%b",
                     t, bus.led_o, bus.led_an_o, bus.frame_o, exp_led, exp_an, exp_frame);
         end
      end
   endtask

   initial begin
      bus.load_i     = 1'b0;
      bus.seg_data_i = '0;
      model_reset();
      test_reset();
      test_basic_load();
      test_coherence();
      test_bypass();
      test_random_loads();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
